// File: rtl/time_ascii_sender.sv
// ============================================================================
// Module      : time_ascii_sender
// Description : Snapshots the stopwatch time on request and streams it as an
//               ASCII line "HH:MM:SS.CC\r\n" (or "HH:MM:SS\r\n") over a
//               valid/ready byte interface toward the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_ascii_sender #(
  parameter int SEND_MSEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_send,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  input  logic       i_tx_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index of the final LF byte in the line.
  localparam logic [3:0] c_LAST_IDX = (SEND_MSEC != 0) ? 4'd12 : 4'd9;
  localparam logic [7:0] c_COLON    = 8'h3A;
  localparam logic [7:0] c_DOT      = 8'h2E;
  localparam logic [7:0] c_CR       = 8'h0D;
  localparam logic [7:0] c_LF       = 8'h0A;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_idx;
  logic [6:0] r_msec;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hour;
  logic       w_capture;
  logic       w_xfer;
  logic [7:0] w_byte;

  // Values are at most 99, so the quotient always fits a single decimal digit.
  function automatic logic [7:0] f_tens_ascii(input logic [6:0] v);
    logic [6:0] q;
    q = v / 7'd10;
    return 8'h30 + {1'b0, q};
  endfunction

  function automatic logic [7:0] f_ones_ascii(input logic [6:0] v);
    logic [6:0] q;
    logic [6:0] r;
    q = v / 7'd10;
    r = v - q * 7'd10;
    return 8'h30 + {1'b0, r};
  endfunction

  assign w_capture = (r_state == S_IDLE) && i_send;
  assign w_xfer    = (r_state == S_SEND) && i_tx_ready;

  // State register, byte index and clamped time snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_msec  <= 7'd0;
      r_sec   <= 6'd0;
      r_min   <= 6'd0;
      r_hour  <= 5'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_idx  <= 4'd0;
        r_msec <= (i_msec > 7'd99) ? 7'd99 : i_msec;
        r_sec  <= (i_sec  > 6'd59) ? 6'd59 : i_sec;
        r_min  <= (i_min  > 6'd59) ? 6'd59 : i_min;
        r_hour <= (i_hour > 5'd23) ? 5'd23 : i_hour;
      end else if (w_xfer) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  // Select the line byte addressed by the index from the snapshot.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = f_tens_ascii({2'b00, r_hour});
      4'd1:    w_byte = f_ones_ascii({2'b00, r_hour});
      4'd2:    w_byte = c_COLON;
      4'd3:    w_byte = f_tens_ascii({1'b0, r_min});
      4'd4:    w_byte = f_ones_ascii({1'b0, r_min});
      4'd5:    w_byte = c_COLON;
      4'd6:    w_byte = f_tens_ascii({1'b0, r_sec});
      4'd7:    w_byte = f_ones_ascii({1'b0, r_sec});
      4'd8:    w_byte = (SEND_MSEC != 0) ? c_DOT : c_CR;
      4'd9:    w_byte = (SEND_MSEC != 0) ? f_tens_ascii(r_msec) : c_LF;
      4'd10:   w_byte = f_ones_ascii(r_msec);
      4'd11:   w_byte = c_CR;
      4'd12:   w_byte = c_LF;
      default: w_byte = 8'h00;
    endcase
  end

  // Next-state and output decode; valid holds until the byte is accepted.
  always_comb begin
    w_next     = r_state;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_send) w_next = S_SEND;
      end
      S_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = w_byte;
        o_busy     = 1'b1;
        if (i_tx_ready && (r_idx == c_LAST_IDX)) w_next = S_DONE;
      end
      S_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
